// File: rtl/memio_uart_tx.sv
// ----------------------------------------------------------------------------
// memio_uart_tx
//   Memory-mapped 8N1 UART transmitter on a valid/ready memory bus.
//   Register window (16 bytes at BASE_ADDR, word offset = mem_addr[3:2]):
//     0 TXDATA  (W)  write with mem_wstrb[0]=1 enqueues mem_wdata[7:0]
//     1 STATUS  (R)  bit0 busy, bit1 full, bit2 empty
//     2 DIVISOR (RW) bits[15:0], clk cycles per bit (0 acts as 1)
//     3 reserved     acknowledged, no effect, reads 0
//
//   Optional feature: define MEMIO_UART_TX_FIFO_EN for a 4-entry TX FIFO;
//   otherwise a single holding register buffers one byte.
//
// Ports:
//   clk        clock, all state on the rising edge
//   nrst       asynchronous active-low reset
//   mem_valid  request valid          mem_ready  one-cycle acknowledge
//   mem_addr   byte address           mem_wdata  write data
//   mem_wstrb  byte strobes (0=read)  mem_rdata  read data (0 unless ready)
//   uart_tx    serial line, idle high
// ----------------------------------------------------------------------------
module memio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Bus-side registers
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, div_d;

    // Transmitter registers
    tx_state_e   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] baud_cnt_q;
    logic [15:0] bit_div_q;
    logic        uart_tx_q;

    // Decode / handshake signals
    logic        sel_s;
    logic [1:0]  off_s;
    logic        is_read_s;
    logic        txwr_s;
    logic        stall_s;
    logic        accept_s;
    logic        enq_s;
    logic        deq_s;
    logic        bit_end_s;
    logic        busy_s;
    logic [31:0] status_s;

    // Queue view shared by both buffer variants
    logic        q_full_s;
    logic        q_empty_s;
    logic [7:0]  q_head_s;

    logic        unused_s;
    assign unused_s = ^{mem_addr[1:0], mem_wdata[31:16]};

    // Request decode; the acknowledge cycle itself never starts a transaction.
    // A TXDATA write into a full queue stalls unless the transmitter frees an
    // entry in the same cycle.
    always_comb begin
        sel_s     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !ready_q;
        off_s     = mem_addr[3:2];
        is_read_s = (mem_wstrb == 4'b0000);
        txwr_s    = sel_s && (off_s == 2'd0) && mem_wstrb[0];
        stall_s   = txwr_s && q_full_s && !deq_s;
        accept_s  = sel_s && !stall_s;
        enq_s     = accept_s && txwr_s;
    end

    // Transmitter timing: a bit ends when the per-frame divisor count expires.
    // The queue head is taken from IDLE, or at the end of STOP for back-to-back.
    always_comb begin
        bit_end_s = (state_q != ST_IDLE) && (baud_cnt_q == (bit_div_q - 16'd1));
        if (q_empty_s) begin
            deq_s = 1'b0;
        end else begin
            deq_s = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end_s);
        end
        busy_s   = (state_q != ST_IDLE) || !q_empty_s;
        status_s = {29'd0, q_empty_s, q_full_s, busy_s};
    end

    // Register file: read mux, DIVISOR byte-lane writes, acknowledge pulse
    always_comb begin
        ready_d = accept_s;
        rdata_d = 32'd0;
        div_d   = div_q;
        if (accept_s) begin
            if (is_read_s) begin
                case (off_s)
                    2'd1:    rdata_d = status_s;
                    2'd2:    rdata_d = {16'd0, div_q};
                    default: rdata_d = 32'd0;
                endcase
            end else if (off_s == 2'd2) begin
                if (mem_wstrb[0]) begin
                    div_d[7:0] = mem_wdata[7:0];
                end else begin
                    div_d[7:0] = div_q[7:0];
                end
                if (mem_wstrb[1]) begin
                    div_d[15:8] = mem_wdata[15:8];
                end else begin
                    div_d[15:8] = div_q[15:8];
                end
            end else begin
                div_d = div_q;
            end
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Bus-side state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            div_q   <= DEFAULT_DIV;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            div_q   <= div_d;
        end
    end

`ifdef MEMIO_UART_TX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    assign q_full_s  = (count_q == 3'd4);
    assign q_empty_s = (count_q == 3'd0);
    assign q_head_s  = fifo_q[rd_ptr_q];

    // Circular pointers wrap naturally at 2 bits; count tracks occupancy
    always_comb begin
        wr_ptr_d = enq_s ? (wr_ptr_q + 2'd1) : wr_ptr_q;
        rd_ptr_d = deq_s ? (rd_ptr_q + 2'd1) : rd_ptr_q;
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            fifo_q[0] <= 8'd0;
            fifo_q[1] <= 8'd0;
            fifo_q[2] <= 8'd0;
            fifo_q[3] <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq_s) begin
                fifo_q[wr_ptr_q] <= mem_wdata[7:0];
            end
        end
    end
`else
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;

    assign q_full_s  = hold_valid_q;
    assign q_empty_s = !hold_valid_q;
    assign q_head_s  = hold_data_q;

    // An enqueue coinciding with a dequeue keeps the register occupied
    always_comb begin
        if (enq_s) begin
            hold_valid_d = 1'b1;
            hold_data_d  = mem_wdata[7:0];
        end else if (deq_s) begin
            hold_valid_d = 1'b0;
            hold_data_d  = hold_data_q;
        end else begin
            hold_valid_d = hold_valid_q;
            hold_data_d  = hold_data_q;
        end
    end

    // Holding register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end
`endif

    // Transmit FSM with registered serial output; the divisor is latched per
    // frame so mid-frame DIVISOR writes only affect the next frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            bit_div_q  <= 16'd1;
            uart_tx_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (deq_s) begin
                        state_q    <= ST_START;
                        shift_q    <= q_head_s;
                        bit_div_q  <= (div_q == 16'd0) ? 16'd1 : div_q;
                        baud_cnt_q <= 16'd0;
                        uart_tx_q  <= 1'b0;
                    end else begin
                        uart_tx_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_q    <= ST_DATA;
                        baud_cnt_q <= 16'd0;
                        bit_idx_q  <= 3'd0;
                        uart_tx_q  <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_q <= 16'd0;
                        if (bit_idx_q == 3'd7) begin
                            state_q   <= ST_STOP;
                            uart_tx_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            uart_tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_q <= 16'd0;
                        if (deq_s) begin
                            state_q   <= ST_START;
                            shift_q   <= q_head_s;
                            bit_div_q <= (div_q == 16'd0) ? 16'd1 : div_q;
                            uart_tx_q <= 1'b0;
                        end else begin
                            state_q   <= ST_IDLE;
                            uart_tx_q <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    uart_tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign uart_tx   = uart_tx_q;

endmodule
